// File: rtl/pc_update_if.sv
// PC update unit bus: control/flag inputs and PC/EPC/status outputs.
interface pc_update_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic [WIDTH-1:0] pc_in;
   logic             pc_write;
   logic             pc_write_cond;
   logic [1:0]       branch_op;
   logic             alu_zero;
   logic             alu_gt;
   logic             stall;
   logic             exc_valid;
   logic [1:0]       exc_cause;
   logic [WIDTH-1:0] pc_out;
   logic [WIDTH-1:0] epc_out;
   logic [1:0]       cause_out;
   logic             exc_pending;
   logic             double_fault;
   logic             branch_taken;
   logic [CNT_W-1:0] upd_count;

   modport master (
      output pc_in, pc_write, pc_write_cond, branch_op,
      output alu_zero, alu_gt, stall, exc_valid, exc_cause,
      input  pc_out, epc_out, cause_out, exc_pending,
      input  double_fault, branch_taken, upd_count
   );

   modport slave (
      input  pc_in, pc_write, pc_write_cond, branch_op,
      input  alu_zero, alu_gt, stall, exc_valid, exc_cause,
      output pc_out, epc_out, cause_out, exc_pending,
      output double_fault, branch_taken, upd_count
   );
endinterface

// File: rtl/pc_update_unit.sv
// PC/EPC/cause registers, branch condition and exception tracking.
// Optional PC_ALIGN_CHECK_EN: misaligned PC targets raise cause 2'b11.
module pc_update_unit #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter int               CNT_W    = 16
) (
   input logic clk,
   input logic reset_n,
   pc_update_if.slave bus
);
   typedef enum logic {RUN, PEND} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic [1:0]       cause_q, cause_d;
   logic             df_q, df_d;
   logic             bt_q, bt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic cond;
   logic want;
   logic mis;
   logic upd;

   always_comb begin
      cond = 1'b0;
      unique case (bus.branch_op)
         2'b00: cond = bus.alu_zero;
         2'b01: cond = !bus.alu_zero;
         2'b10: cond = bus.alu_zero | !bus.alu_gt;
         2'b11: cond = bus.alu_gt;
      endcase
   end

   assign want = !bus.stall &
                 (bus.pc_write | (bus.pc_write_cond & cond));

`ifdef PC_ALIGN_CHECK_EN
   assign mis = want & (bus.pc_in[1:0] != 2'b00);
`else
   assign mis = 1'b0;
`endif

   assign upd = want & !mis;

   always_comb begin
      pc_d    = pc_q;
      epc_d   = epc_q;
      cause_d = cause_q;
      df_d    = df_q;
      bt_d    = bt_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      if (!bus.stall) begin
         if (upd) begin
            pc_d  = bus.pc_in;
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (bus.pc_write_cond & !bus.pc_write)
            bt_d = cond;
         unique case (state_q)
            RUN: begin
               // fetch already advanced PC, so the faulting one is 4 back
               if (bus.exc_valid) begin
                  epc_d   = pc_q - WIDTH'(4);
                  cause_d = bus.exc_cause;
                  if (!upd)
                     state_d = PEND;
               end else if (mis) begin
                  epc_d   = pc_q;
                  cause_d = 2'b11;
                  state_d = PEND;
               end
            end
            PEND: begin
               if (bus.exc_valid | mis)
                  df_d = 1'b1;
               if (upd)
                  state_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         epc_q   <= '0;
         cause_q <= 2'b00;
         df_q    <= 1'b0;
         bt_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
         df_q    <= df_d;
         bt_q    <= bt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.pc_out       = pc_q;
   assign bus.epc_out      = epc_q;
   assign bus.cause_out    = cause_q;
   assign bus.exc_pending  = (state_q == PEND);
   assign bus.double_fault = df_q;
   assign bus.branch_taken = bt_q;
   assign bus.upd_count    = cnt_q;
endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
- Program-counter stage of the multicycle CPU, sitting directly downstream of the PC-source selection mux; its pc_in is that mux's output.
- Holds PC, EPC and the exception cause register.
- Evaluates the conditional-write branch condition from ALU flags.
- Tracks a pending exception until control redirects PC to the handler.
- Counts PC updates for debug.

Parameters:
- WIDTH, 32, PC/EPC width in bits
- RESET_PC, 32'h0000_0000, PC value after reset
- CNT_W, 16, width of the PC-update counter

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- pc_in  in  WIDTH  next-PC candidate from the PC-source mux
- pc_write  in  1  unconditional PC write request
- pc_write_cond  in  1  conditional PC write request (branches)
- branch_op  in  2  00 beq, 01 bne, 10 ble, 11 bgt
- alu_zero  in  1  ALU zero flag
- alu_gt  in  1  ALU greater-than flag (A > B, signed)
- stall  in  1  freeze: no state changes this cycle
- exc_valid  in  1  exception raised this cycle
- exc_cause  in  2  cause code (00 opcode, 01 overflow, 10 div-by-zero)
- pc_out  out  WIDTH  current PC
- epc_out  out  WIDTH  exception PC
- cause_out  out  2  latched cause
- exc_pending  out  1  exception captured, handler redirect not yet done
- double_fault  out  1  sticky; exception raised while pending
- branch_taken  out  1  registered; last conditional write was taken
- upd_count  out  CNT_W  number of PC updates, wraps

Behaviour:
- Reset (async, reset_n=0): pc_out=RESET_PC; epc_out=0; cause_out=0; exc_pending=0; double_fault=0; branch_taken=0; upd_count=0; FSM=RUN.
- Condition: cond = beq: alu_zero; bne: !alu_zero; ble: alu_zero | !alu_gt; bgt: alu_gt.
- do_upd = !stall & (pc_write | (pc_write_cond & cond)).
  - pc_write has priority; cond is ignored when pc_write=1.
- On do_upd: pc_out <= pc_in at the next rising edge (1-cycle latency); upd_count <= upd_count+1 (wraps from all-ones to 0).
- branch_taken: updated only on cycles with !stall & pc_write_cond & !pc_write; holds cond. Holds its value otherwise.
- stall=1: PC, EPC, cause, FSM, counter and branch_taken all hold; exc_valid is ignored.
- FSM states RUN and PEND; exc_pending = (state==PEND).
  - RUN, !stall & exc_valid: epc <= pc_out - 4 (PC has already been incremented by fetch; arithmetic is modulo 2^WIDTH, so 0 wraps to FFFF_FFFC). cause <= exc_cause.
    - If do_upd in the same cycle: PC takes pc_in and the state stays RUN (immediate redirect).
    - Otherwise: go to PEND.
  - PEND, !stall & do_upd: PC <= pc_in; go to RUN.
  - PEND, !stall & exc_valid: EPC and cause unchanged; double_fault <= 1 (cleared only by reset). If do_upd also occurs, go to RUN.
  - RUN, no exception: no EPC/cause change.
- Reset asserted mid-operation forces all reset values immediately, regardless of clk.
- No combinational path from any input to any output.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined: a do_upd whose pc_in[1:0] != 0 is suppressed.
  - PC holds; counter does not increment.
  - Misaligned-target exception is taken: epc <= pc_out, cause <= 2'b11, state -> PEND.
  - If exc_valid coincides, exc_valid wins (its cause and the pc_out-4 EPC are recorded).
  - If already in PEND, double_fault is set.
- Undefined: no alignment check; pc_in is loaded unmodified and cause 2'b11 is never produced.

Test Plan:
- Reset: release reset_n with no writes -> pc_out=0, upd_count=0, epc_out=0, exc_pending=0.
- Unconditional write: pc_in=0x40, pc_write=1 for one cycle -> pc_out=0x40 next edge, upd_count=1. Repeat with stall=1 -> pc_out remains 0x40, count stays 1.
- Branches:
  - pc_write_cond=1, branch_op=01, alu_zero=1, pc_in=0x80 -> pc_out unchanged, branch_taken=0.
  - branch_op=00, alu_zero=1 -> pc_out=0x80, branch_taken=1.
  - branch_op=10, alu_gt=1, alu_zero=0 -> not taken.
- Exception: pc_out=0x104, exc_valid=1, exc_cause=01 -> epc_out=0x100, cause_out=01, exc_pending=1. Then pc_write with pc_in=0x2000 -> pc_out=0x2000, exc_pending=0.
- Double fault: while pending, exc_valid=1, exc_cause=10 -> epc_out/cause_out unchanged, double_fault=1 and stays 1 after redirect. Only reset_n=0 clears it.
- Counter wrap: CNT_W=4, 16 updates -> upd_count=0. With PC_ALIGN_CHECK_EN: pc_write with pc_in=0x42 -> pc_out unchanged, cause_out=11, epc_out=old pc_out, exc_pending=1.
